fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end and successor to the single-register PC update stage. Owns the architectural fetch PC and issues pipelined requests to instruction memory over a valid/ready request channel. Accepts in-order responses of arbitrary latency into a FETCH_DEPTH-entry queue and presents {pc, instr} pairs to decode with a valid/ready handshake. A redirect from execute flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue_unit_if.sv | 53 +++++
 rtl/fetch_queue_ram.sv | 68 ++++++
 rtl/fetch_queue_unit.sv | 137 +++++++++++++
 tb/tb_fetch_queue_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch front end.
//   FQ_XLEN / FQ_ILEN : widths of the queue entry fields.
//   INSTR_BYTES       : fetch PC increment per instruction.
//   RESET_VEC_DEF     : default PC loaded on reset.
//   fq_entry_t        : one fetch-queue entry {pc, instr, pending, valid}.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int FQ_XLEN     = 32;
  localparam int FQ_ILEN     = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [FQ_XLEN-1:0] RESET_VEC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_ILEN-1:0] instr;
    logic               pending;
    logic               valid;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit_if
// Bundles the fetch unit's memory, redirect and decode channels.
//   imem_req_*     : request to instruction memory (valid/ready, address)
//   imem_rsp_*     : in-order instruction response (no backpressure)
//   redirect_*     : PC redirect from execute
//   dec_*          : {pc, instr} handed to decode (valid/ready)
//   fetch_misalign : only present when FETCH_MISALIGN_CHK_EN is defined
// Modports: master = fetch unit side, slave = memory/execute/decode side.
// ---------------------------------------------------------------------------
interface fetch_queue_unit_if
  import fetch_pkg::*;
#(
  parameter int XLEN = FQ_XLEN,
  parameter int ILEN = FQ_ILEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [ILEN-1:0] dec_instr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            fetch_misalign;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, fetch_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, fetch_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
`else
  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
`endif

endinterface

// File: rtl/fetch_queue_ram.sv
// ---------------------------------------------------------------------------
// fetch_queue_ram
// FETCH_DEPTH-entry storage for the fetch queue.
//   clk, rst    : clock, synchronous active-high reset (flags only)
//   flush       : invalidate every entry next cycle
//   rd_addr     : read port address -> rd_entry (combinational)
//   alloc_*     : write pc into a new entry and mark it valid + pending
//   fill_*      : write instr into a pending entry and mark it filled
//   pop_*       : invalidate the entry handed to decode
// pc/instr storage is never reset; only the valid/pending flags are.
// ---------------------------------------------------------------------------
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int FETCH_DEPTH = 4,
  localparam int AW = $clog2(FETCH_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [AW-1:0]      rd_addr,
  output fq_entry_t          rd_entry,
  input  logic               alloc_en,
  input  logic [AW-1:0]      alloc_addr,
  input  logic [FQ_XLEN-1:0] alloc_pc,
  input  logic               fill_en,
  input  logic [AW-1:0]      fill_addr,
  input  logic [FQ_ILEN-1:0] fill_instr,
  input  logic               pop_en,
  input  logic [AW-1:0]      pop_addr
);

  logic [FQ_XLEN-1:0]   pc_q    [FETCH_DEPTH];
  logic [FQ_ILEN-1:0]   instr_q [FETCH_DEPTH];
  logic [FETCH_DEPTH-1:0] valid_q;
  logic [FETCH_DEPTH-1:0] pending_q;

  // Payload storage, no reset.
  always_ff @(posedge clk) begin
    if (alloc_en) pc_q[alloc_addr] <= alloc_pc;
    if (fill_en)  instr_q[fill_addr] <= fill_instr;
  end

  // Alloc, fill and pop always target distinct entries, so they can all
  // update the flag vectors in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q   <= '0;
      pending_q <= '0;
    end else begin
      if (alloc_en) begin
        valid_q[alloc_addr]   <= 1'b1;
        pending_q[alloc_addr] <= 1'b1;
      end
      if (fill_en) pending_q[fill_addr] <= 1'b0;
      if (pop_en)  valid_q[pop_addr]    <= 1'b0;
    end
  end

  always_comb begin
    rd_entry         = '0;
    rd_entry.pc      = pc_q[rd_addr];
    rd_entry.instr   = instr_q[rd_addr];
    rd_entry.pending = pending_q[rd_addr];
    rd_entry.valid   = valid_q[rd_addr];
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
// Instruction-fetch front end: owns the fetch PC, issues pipelined requests
// to instruction memory, queues in-order responses and hands {pc, instr}
// pairs to decode. A redirect flushes the queue and arranges for responses
// still in flight to be discarded on return.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_queue_unit_if.master (imem req/rsp, redirect, decode)
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   -> misaligned redirect targets raise bus.fetch_misalign and
//                block issue until the next aligned redirect
//   undefined -> redirect targets have bits [1:0] forced to zero
// Parameters: XLEN/ILEN must match the fq_entry_t field widths in fetch_pkg;
// FETCH_DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN        = FQ_XLEN,
  parameter int              ILEN        = FQ_ILEN,
  parameter int              FETCH_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_VEC   = RESET_VEC_DEF
) (
  input logic                clk,
  input logic                rst,
  fetch_queue_unit_if.master bus
);

  localparam int AW = $clog2(FETCH_DEPTH);
  localparam int PW = AW + 1;
  // Drops can pile up across back-to-back redirects, so give the counter
  // headroom beyond one queue's worth of outstanding requests.
  localparam int DW = AW + 4;

  localparam logic [PW-1:0]   DEPTH_P    = PW'(FETCH_DEPTH);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  logic [XLEN-1:0] fetch_pc_q;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [PW-1:0]   fill_q;
  logic [DW-1:0]   drop_q;

  logic [PW-1:0]   alloc_cnt;
  logic [PW-1:0]   pend_cnt;
  logic            issue_block;
  logic            req_hs;
  logic            rsp_seen;
  logic            drop_hit;
  logic            fill_hit;
  logic            pop;
  fq_entry_t       head_entry;

  // head..fill-1 are filled entries, fill..tail-1 are awaiting a response.
  assign alloc_cnt = tail_q - head_q;
  assign pend_cnt  = tail_q - fill_q;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;
  assign issue_block        = misalign_q;
  assign bus.fetch_misalign = misalign_q;
`else
  assign issue_block = 1'b0;
`endif

  // Issue depends only on registered state, so a pop can never re-open
  // issue within the same cycle.
  assign bus.imem_req_valid = !rst && (alloc_cnt < DEPTH_P) && !issue_block;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_hs             = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_seen = !rst && bus.imem_rsp_valid;
  assign drop_hit = rsp_seen && (drop_q != '0);
  assign fill_hit = rsp_seen && (drop_q == '0) && (pend_cnt != '0);

  // Decode sees only registered queue contents; outputs read zero when the
  // head is empty or still pending.
  assign bus.dec_valid = head_entry.valid && !head_entry.pending;
  assign bus.dec_pc    = bus.dec_valid ? head_entry.pc    : '0;
  assign bus.dec_instr = bus.dec_valid ? head_entry.instr : '0;
  assign pop           = bus.dec_valid && bus.dec_ready;

  fetch_queue_ram #(
    .FETCH_DEPTH (FETCH_DEPTH)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.redirect_valid),
    .rd_addr    (head_q[AW-1:0]),
    .rd_entry   (head_entry),
    .alloc_en   (req_hs && !bus.redirect_valid),
    .alloc_addr (tail_q[AW-1:0]),
    .alloc_pc   (fetch_pc_q),
    .fill_en    (fill_hit && !bus.redirect_valid),
    .fill_addr  (fill_q[AW-1:0]),
    .fill_instr (bus.imem_rsp_data),
    .pop_en     (pop),
    .pop_addr   (head_q[AW-1:0])
  );

  // PC, queue pointers and drop counter. On a redirect every pending entry,
  // plus a request accepted this cycle, becomes a response to throw away;
  // a response arriving this cycle has already settled one of those.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_VEC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      drop_q     <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      drop_q <= drop_q + DW'(pend_cnt) + DW'(req_hs) - DW'(rsp_seen);
`ifdef FETCH_MISALIGN_CHK_EN
      fetch_pc_q <= bus.redirect_pc;
      misalign_q <= |(bus.redirect_pc & ~ALIGN_MASK);
`else
      fetch_pc_q <= bus.redirect_pc & ALIGN_MASK;
`endif
    end else begin
      if (req_hs) begin
        tail_q     <= tail_q + PW'(1);
        fetch_pc_q <= fetch_pc_q + STEP;
      end
      if (fill_hit) fill_q <= fill_q + PW'(1);
      if (pop)      head_q <= head_q + PW'(1);
      if (drop_hit) drop_q <= drop_q - DW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_unit
// Scoreboard bench for fetch_queue_unit. A behavioural model tracks the
// fetch PC, queue occupancy, fill state and drop count; a memory model
// returns instructions in order after a configurable latency. Build with
// FETCH_MISALIGN_CHK_EN defined to cover the misalignment feature.
// ---------------------------------------------------------------------------
module tb_fetch_queue_unit;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  fetch_queue_unit_if #(.XLEN(32), .ILEN(32)) bus ();

  fetch_queue_unit #(
    .XLEN        (32),
    .ILEN        (32),
    .FETCH_DEPTH (DEPTH),
    .RESET_VEC   (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [31:0] pc;
    bit          filled;
  } sb_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  sb_t         sbq[$];
  mem_t        memq[$];
  int          checks     = 0;
  int          failures   = 0;
  int          cyc        = 0;
  int          lat        = 1;
  int          drop_model = 0;
  int          req_count  = 0;
  logic [31:0] model_pc   = 32'h0;
  bit          model_mis  = 1'b0;
  bit          want_first = 1'b0;
  logic [31:0] first_pc   = 32'hFFFF_FFFF;
  int          k;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return 32'h0000_0013 ^ (a << 7);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit rdy, input bit drdy, input bit rv,
                               input logic [31:0] rpc, input int n);
    rst                = r;
    bus.imem_req_ready = rdy;
    bus.dec_ready      = drdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Instruction memory: in-order responses, each one 'lat' cycles after its
  // request was accepted.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = instrOf(memq[0].addr);
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
      end
    end
  end

  // Mid-cycle monitor: compare against the model, then advance the model by
  // whatever happened in this cycle.
  always @(negedge clk) begin : monitor
    bit exp_dv;
    bit exp_rv;
    bit req_hs;
    int unfilled;
    exp_dv = (sbq.size() > 0) && sbq[0].filled;
    exp_rv = !rst && (sbq.size() < DEPTH) && !model_mis;
    checkOutput("dec_valid", 32'(bus.dec_valid), 32'(exp_dv));
    checkOutput("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (bus.imem_req_valid) checkOutput("req_addr", bus.imem_req_addr, model_pc);
`ifdef FETCH_MISALIGN_CHK_EN
    checkOutput("misalign", 32'(bus.fetch_misalign), 32'(model_mis));
`endif
    req_hs = bus.imem_req_valid && bus.imem_req_ready;
    if (rst) begin
      sbq.delete();
      memq.delete();
      drop_model = 0;
      model_pc   = 32'h0;
      model_mis  = 1'b0;
      want_first = 1'b1;
      first_pc   = 32'hFFFF_FFFF;
    end else begin
      if (bus.dec_valid && bus.dec_ready && sbq.size() > 0 && sbq[0].filled) begin
        checkOutput("dec_pc", bus.dec_pc, sbq[0].pc);
        checkOutput("dec_instr", bus.dec_instr, instrOf(sbq[0].pc));
        if (want_first) begin
          first_pc   = bus.dec_pc;
          want_first = 1'b0;
        end
        void'(sbq.pop_front());
      end
      if (bus.imem_rsp_valid) begin
        if (memq.size() > 0) void'(memq.pop_front());
        if (drop_model > 0) begin
          drop_model--;
        end else begin
          for (int i = 0; i < sbq.size(); i++) begin
            if (!sbq[i].filled) begin
              sbq[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (req_hs) req_count++;
      if (bus.redirect_valid) begin
        unfilled = 0;
        foreach (sbq[i]) if (!sbq[i].filled) unfilled++;
        drop_model += unfilled + (req_hs ? 1 : 0);
        sbq.delete();
`ifdef FETCH_MISALIGN_CHK_EN
        model_pc  = bus.redirect_pc;
        model_mis = |bus.redirect_pc[1:0];
`else
        model_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
`endif
        want_first = 1'b1;
        first_pc   = 32'hFFFF_FFFF;
      end else if (req_hs) begin
        sbq.push_back('{pc: model_pc, filled: 1'b0});
        model_pc += 32'd4;
      end
      if (req_hs) memq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
    end
  end

  initial begin
    rst                = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.dec_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset release, 1-cycle memory, streaming from RESET_VEC.
    lat = 1;
    applyStimulus(1, 1, 1, 0, 32'h0, 2);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_dec_valid", 32'(bus.dec_valid), 32'd0);
    checkOutput("reset_dec_pc", bus.dec_pc, 32'h0);
    checkOutput("reset_dec_instr", bus.dec_instr, 32'h0);
    checkOutput("reset_req_addr", bus.imem_req_addr, 32'h0);
    k = 0;
    while (!bus.dec_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("first_dec_latency", 32'(k), 32'd2);
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 1, 0, 32'h0, 12);

    // Decode stalled: exactly DEPTH requests, then issue resumes after a pop.
    applyStimulus(1, 1, 0, 0, 32'h0, 2);
    req_count = 0;
    applyStimulus(0, 1, 0, 0, 32'h0, 10);
    checkOutput("full_req_count", 32'(req_count), 32'd4);
    checkOutput("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
    applyStimulus(0, 1, 1, 0, 32'h0, 12);
    checkOutput("resume_req_count", 32'(req_count), 32'd15);

    // 3-cycle memory, redirect with three requests outstanding.
    lat = 3;
    applyStimulus(1, 1, 1, 0, 32'h0, 2);
    applyStimulus(0, 1, 1, 0, 32'h0, 2);
    applyStimulus(0, 1, 1, 1, 32'h100, 1);
    applyStimulus(0, 1, 1, 0, 32'h0, 14);
    checkOutput("redirect_first_pc", first_pc, 32'h100);

    // Redirects coinciding with request handshakes and responses, the second
    // one while stale responses are still being dropped.
    lat = 2;
    applyStimulus(1, 1, 1, 0, 32'h0, 2);
    applyStimulus(0, 1, 1, 0, 32'h0, 6);
    applyStimulus(0, 1, 1, 1, 32'h40, 1);
    applyStimulus(0, 1, 1, 0, 32'h0, 1);
    applyStimulus(0, 1, 1, 1, 32'h80, 1);
    applyStimulus(0, 1, 1, 0, 32'h0, 14);
    checkOutput("double_redirect_first_pc", first_pc, 32'h80);

    // Misaligned redirect target.
    lat = 1;
    applyStimulus(1, 1, 1, 0, 32'h0, 2);
    applyStimulus(0, 1, 1, 0, 32'h0, 4);
    applyStimulus(0, 1, 1, 1, 32'h102, 1);
`ifdef FETCH_MISALIGN_CHK_EN
    req_count = 0;
    applyStimulus(0, 1, 1, 0, 32'h0, 6);
    checkOutput("misalign_set", 32'(bus.fetch_misalign), 32'd1);
    checkOutput("misalign_no_req", 32'(req_count), 32'd0);
    applyStimulus(0, 1, 1, 1, 32'h200, 1);
    applyStimulus(0, 1, 1, 0, 32'h0, 8);
    checkOutput("misalign_clear", 32'(bus.fetch_misalign), 32'd0);
    checkOutput("aligned_first_pc", first_pc, 32'h200);
`else
    applyStimulus(0, 1, 1, 0, 32'h0, 8);
    checkOutput("forced_align_first_pc", first_pc, 32'h100);
`endif

    // Reset mid-stream with the queue full.
    lat = 1;
    applyStimulus(1, 1, 0, 0, 32'h0, 2);
    applyStimulus(0, 1, 0, 0, 32'h0, 8);
    applyStimulus(1, 1, 0, 0, 32'h0, 1);
    @(negedge clk);
    checkOutput("midrst_dec_valid", 32'(bus.dec_valid), 32'd0);
    checkOutput("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 1, 0, 32'h0, 10);
    checkOutput("midrst_first_pc", first_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
